control_unidad_pipe: RTL and testbench
======================================

# control_unidad_pipe

Pipelined main-control block for the 5-stage MIPS core. It decodes the ID-stage instruction into an extended control word and registers it into the ID/EX boundary, so control is 1 cycle behind decode. It also detects load-use hazards, inserts bubbles on stall or redirect, flags illegal opcodes, and runs a HALT drain state machine that the debug unit polls.

## Interface
- NB_OP, 6, opcode width
- NB_FUNCT, 6, funct width
- NB_REG, 5, register-index width
- NB_ALUOP, 3, ALU-op code width
- DRAIN_CYCLES, 3, cycles to drain the pipe after HALT before `o_halted`
- `i_clk` in 1: single clock, rising edge
- `i_rst_n` in 1: asynchronous, active-low reset
- `i_enable` in 1: global step/run enable from the debug unit; low freezes all state
- `i_valid` in 1: IF/ID holds a real instruction
- `i_opcode` in NB_OP: instruction bits [31:26]
- `i_funct` in NB_FUNCT: instruction bits [5:0]
- `i_rs`, `i_rt` in NB_REG: source register fields
- `i_redirect` in 1: taken branch or jump resolved in EX
- `o_stall` out 1: hold PC and IF/ID (combinational)
- `o_flush` out 1: clear IF/ID (combinational, equals `i_redirect & i_enable`)
- `o_ex_valid`, `o_ex_regdst`, `o_ex_alusrc`, `o_ex_memread`, `o_ex_memwrite`, `o_ex_memtoreg`, `o_ex_regwrite`, `o_ex_branch`, `o_ex_branch_ne`, `o_ex_jump`, `o_ex_jump_reg`, `o_ex_link` out 1 each: registered control word
- `o_ex_aluop` out NB_ALUOP: registered ALU-op code
- `o_ex_rt` out NB_REG: registered rt, used for hazard compare
- `o_illegal` out 1: 1-cycle pulse when an illegal valid opcode is decoded
- `o_halted` out 1: pipe drained after HALT

## Operation
- **Decode**
  - R-type (000000) sets regdst, regwrite and aluop=010. If funct=001000 (JR), it sets jump_reg only.
  - J (000010) sets jump.
  - JAL (000011) sets jump, link and regwrite.
  - BEQ (000100) and BNE (000101) set branch or branch_ne, with aluop=001.
  - ADDI (001000) sets alusrc, regwrite and aluop=000.
  - SLTI (001010) sets alusrc, regwrite and aluop=011.
  - ANDI, ORI and XORI (001100, 001101, 001110) set alusrc and regwrite, with aluop 100, 101 and 110.
  - LUI (001111) sets alusrc, regwrite and aluop=111.
  - LW (100011) sets alusrc, memread, memtoreg, regwrite and aluop=000.
  - SW (101011) sets alusrc, memwrite and aluop=000.
  - HALT (111111) produces a bubble and starts the drain.
  - Any other opcode produces a bubble and pulses `o_illegal`.
- **Bubble:** every control bit and `o_ex_valid` are 0, and aluop=000.
- **Register-use rule:** `uses_rt` is true for R-type (except JR), BEQ, BNE and SW. rs is used by every instruction except J, JAL, LUI and HALT.
- **Load-use hazard:** `o_ex_valid & o_ex_memread & o_ex_rt!=0`, and `o_ex_rt` matches a used rs or rt of a valid ID instruction. On a hazard, `o_stall`=1 and a bubble enters EX.
- **Priority:** redirect > hazard stall > HALT/illegal > normal. When `i_redirect`=1, the EX input is a bubble, `o_stall`=0 and `o_illegal`=0.
- **FSM:**
  - RUN goes to DRAIN when a valid HALT is decoded without redirect. The counter loads DRAIN_CYCLES-1.
  - DRAIN inserts bubbles, forces `o_stall`=1, ignores redirect and decrements each enabled cycle. At 0 it moves to HALTED.
  - HALTED keeps `o_halted`=1 and `o_stall`=1, and EX holds bubbles. It exits only on reset.
- **`i_enable`=0:** no register, counter or FSM update. `o_stall`=0, `o_flush`=0 and `o_illegal`=0.

## Timing
- Latency: ID decode appears on the `o_ex_*` outputs 1 cycle after the enabled rising edge.
- Reset (async assert, synchronous release):
  - all `o_ex_*` outputs 0, including `o_ex_rt`
  - `o_illegal`=0 and `o_halted`=0
  - FSM in RUN, counter 0
- Reset in DRAIN or HALTED returns to RUN immediately.
- A stall lasts exactly 1 cycle per load-use. The cycle after the bubble, the hazard is false because `o_ex_valid`=0.
- `o_illegal` is registered and aligned with the bubble in EX.
- HALT decoded at edge N: `o_halted`=1 after edge N+DRAIN_CYCLES. DRAIN_CYCLES=1 is legal.

## Structure
- Package `mips_ctrl_pkg`:
  - opcode and funct constants
  - ALU-op encodings 000..111
  - FSM state enum {RUN, DRAIN, HALTED}
  - packed control-word struct
- Sub-module `control_decoder`: combinational opcode/funct to control word plus `uses_rs`, `uses_rt`, `is_halt`, `is_illegal`. This module instantiates it and owns the hazard logic, the pipeline register and the FSM.

## Test plan
- ADDI then ORI then LW, no hazards:
  - aluop 000, 101, 000 appear 1 cycle after each decode
  - alusrc=1 and regwrite=1 for all three
  - memtoreg=1 only for LW
- LW with rt=5, then ADD with rs=5:
  - `o_stall`=1 for 1 cycle, then EX holds a bubble
  - ADD reaches EX on the following cycle
  - repeat with rt=0: no stall
- LW rt=5, then `i_redirect`=1 in the same cycle as a dependent ID instruction: `o_flush`=1, `o_stall`=0, EX holds a bubble.
- Opcode 010001:
  - `o_illegal` pulses once
  - `o_ex_valid`=0
  - the next ADDI proceeds normally
- HALT with DRAIN_CYCLES=3:
  - `o_stall`=1 from the decode cycle
  - `o_halted` rises after 3 enabled edges, with `i_enable` toggled mid-drain, extending the drain by the disabled cycles
  - `i_rst_n` low clears `o_halted` asynchronously

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the pipelined MIPS main-control block.
package mips_ctrl_pkg;

  // Opcode field values (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // Funct field values (instruction bits [5:0])
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  // ALU-op encodings handed to the ALU control in EX
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_SLT   = 3'b011;
  localparam logic [2:0] ALUOP_AND   = 3'b100;
  localparam logic [2:0] ALUOP_OR    = 3'b101;
  localparam logic [2:0] ALUOP_XOR   = 3'b110;
  localparam logic [2:0] ALUOP_LUI   = 3'b111;

  // HALT drain state machine
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } ctrl_state_e;

  // Extended control word carried across the ID/EX boundary
  typedef struct packed {
    logic       valid;
    logic       regdst;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic       jump_reg;
    logic       link;
    logic [2:0] aluop;
  } ctrl_word_t;

  // A bubble is the all-zero control word (aluop=000, valid=0)
  function automatic ctrl_word_t ctrl_bubble();
    ctrl_word_t w;
    w = '0;
    return w;
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational opcode/funct decoder producing the control word and register-use flags.
module control_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]  i_opcode,
  input  logic [5:0]  i_funct,
  output ctrl_word_t  o_word,
  output logic        o_uses_rs,
  output logic        o_uses_rt,
  output logic        o_is_halt,
  output logic        o_is_illegal
);

  // Decode the opcode (and funct for R-type) into a control word
  always_comb begin
    o_word       = ctrl_bubble();
    o_uses_rs    = 1'b1;
    o_uses_rt    = 1'b0;
    o_is_halt    = 1'b0;
    o_is_illegal = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_word.valid = 1'b1;
        if (i_funct == FUNCT_JR) begin
          o_word.jump_reg = 1'b1;
          o_uses_rt       = 1'b0;
        end else begin
          o_word.regdst   = 1'b1;
          o_word.regwrite = 1'b1;
          o_word.aluop    = ALUOP_RTYPE;
          o_uses_rt       = 1'b1;
        end
      end
      OP_J: begin
        o_word.valid = 1'b1;
        o_word.jump  = 1'b1;
        o_uses_rs    = 1'b0;
      end
      OP_JAL: begin
        o_word.valid    = 1'b1;
        o_word.jump     = 1'b1;
        o_word.link     = 1'b1;
        o_word.regwrite = 1'b1;
        o_uses_rs       = 1'b0;
      end
      OP_BEQ: begin
        o_word.valid  = 1'b1;
        o_word.branch = 1'b1;
        o_word.aluop  = ALUOP_SUB;
        o_uses_rt     = 1'b1;
      end
      OP_BNE: begin
        o_word.valid     = 1'b1;
        o_word.branch_ne = 1'b1;
        o_word.aluop     = ALUOP_SUB;
        o_uses_rt        = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
        o_word.valid    = 1'b1;
        o_word.alusrc   = 1'b1;
        o_word.regwrite = 1'b1;
        case (i_opcode)
          OP_SLTI: o_word.aluop = ALUOP_SLT;
          OP_ANDI: o_word.aluop = ALUOP_AND;
          OP_ORI:  o_word.aluop = ALUOP_OR;
          OP_XORI: o_word.aluop = ALUOP_XOR;
          default: o_word.aluop = ALUOP_ADD;
        endcase
      end
      OP_LUI: begin
        o_word.valid    = 1'b1;
        o_word.alusrc   = 1'b1;
        o_word.regwrite = 1'b1;
        o_word.aluop    = ALUOP_LUI;
        o_uses_rs       = 1'b0;
      end
      OP_LW: begin
        o_word.valid    = 1'b1;
        o_word.alusrc   = 1'b1;
        o_word.memread  = 1'b1;
        o_word.memtoreg = 1'b1;
        o_word.regwrite = 1'b1;
        o_word.aluop    = ALUOP_ADD;
      end
      OP_SW: begin
        o_word.valid    = 1'b1;
        o_word.alusrc   = 1'b1;
        o_word.memwrite = 1'b1;
        o_word.aluop    = ALUOP_ADD;
        o_uses_rt       = 1'b1;
      end
      OP_HALT: begin
        o_is_halt = 1'b1;
        o_uses_rs = 1'b0;
      end
      default: begin
        o_is_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_unidad_pipe.sv
// Pipelined main control: decode into ID/EX, load-use stall, bubbles, HALT drain FSM.
module control_unidad_pipe
  import mips_ctrl_pkg::*;
#(
  parameter int NB_OP        = 6,
  parameter int NB_FUNCT     = 6,
  parameter int NB_REG       = 5,
  parameter int NB_ALUOP     = 3,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic                i_valid,
  input  logic [NB_OP-1:0]    i_opcode,
  input  logic [NB_FUNCT-1:0] i_funct,
  input  logic [NB_REG-1:0]   i_rs,
  input  logic [NB_REG-1:0]   i_rt,
  input  logic                i_redirect,
  output logic                o_stall,
  output logic                o_flush,
  output logic                o_ex_valid,
  output logic                o_ex_regdst,
  output logic                o_ex_alusrc,
  output logic                o_ex_memread,
  output logic                o_ex_memwrite,
  output logic                o_ex_memtoreg,
  output logic                o_ex_regwrite,
  output logic                o_ex_branch,
  output logic                o_ex_branch_ne,
  output logic                o_ex_jump,
  output logic                o_ex_jump_reg,
  output logic                o_ex_link,
  output logic [NB_ALUOP-1:0] o_ex_aluop,
  output logic [NB_REG-1:0]   o_ex_rt,
  output logic                o_illegal,
  output logic                o_halted
);

  // Counter wide enough to hold DRAIN_CYCLES-1 (at least one bit)
  localparam int NB_CNT = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] CNT_LOAD = NB_CNT'(DRAIN_CYCLES - 1);

  ctrl_word_t          dec_word_s;
  logic                dec_uses_rs_s;
  logic                dec_uses_rt_s;
  logic                dec_is_halt_s;
  logic                dec_is_illegal_s;
  logic                hazard_s;
  logic                stall_s;

  ctrl_state_e         state_q, state_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  ctrl_word_t          ex_q, ex_d;
  logic [NB_REG-1:0]   ex_rt_q, ex_rt_d;
  logic                illegal_q, illegal_d;
  logic                halted_q, halted_d;

  control_decoder u_decoder (
    .i_opcode     (i_opcode[5:0]),
    .i_funct      (i_funct[5:0]),
    .o_word       (dec_word_s),
    .o_uses_rs    (dec_uses_rs_s),
    .o_uses_rt    (dec_uses_rt_s),
    .o_is_halt    (dec_is_halt_s),
    .o_is_illegal (dec_is_illegal_s)
  );

  // Load-use hazard: a valid load in EX writes a register the ID instruction reads
  always_comb begin
    hazard_s = 1'b0;
    if (ex_q.valid && ex_q.memread && (ex_rt_q != '0) && i_valid) begin
      hazard_s = (dec_uses_rs_s && (i_rs == ex_rt_q)) ||
                 (dec_uses_rt_s && (i_rt == ex_rt_q));
    end else begin
      hazard_s = 1'b0;
    end
  end

  // Next-state: FSM, drain counter, ID/EX control word and illegal flag
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ex_d      = ex_q;
    ex_rt_d   = ex_rt_q;
    illegal_d = illegal_q;
    stall_s   = 1'b0;
    if (i_enable) begin
      ex_d      = ctrl_bubble();
      ex_rt_d   = '0;
      illegal_d = 1'b0;
      case (state_q)
        ST_RUN: begin
          if (i_redirect) begin
            stall_s = 1'b0;
          end else if (hazard_s) begin
            stall_s = 1'b1;
          end else if (i_valid && dec_is_halt_s) begin
            // Hold fetch from the HALT decode onward; the drain starts now
            stall_s = 1'b1;
            state_d = ST_DRAIN;
            cnt_d   = CNT_LOAD;
          end else if (i_valid && dec_is_illegal_s) begin
            illegal_d = 1'b1;
          end else if (i_valid) begin
            ex_d    = dec_word_s;
            ex_rt_d = i_rt;
          end else begin
            stall_s = 1'b0;
          end
        end
        ST_DRAIN: begin
          stall_s = 1'b1;
          if (cnt_q == '0) begin
            state_d = ST_HALTED;
          end else begin
            cnt_d = cnt_q - NB_CNT'(1);
          end
        end
        ST_HALTED: begin
          stall_s = 1'b1;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end else begin
      stall_s = 1'b0;
    end
    halted_d = (state_d == ST_HALTED);
  end

  // State and ID/EX pipeline registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      ex_q      <= ctrl_bubble();
      ex_rt_q   <= '0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ex_q      <= ex_d;
      ex_rt_q   <= ex_rt_d;
      illegal_q <= illegal_d;
      halted_q  <= halted_d;
    end
  end

  assign o_stall        = stall_s;
  assign o_flush        = i_redirect & i_enable;
  assign o_ex_valid     = ex_q.valid;
  assign o_ex_regdst    = ex_q.regdst;
  assign o_ex_alusrc    = ex_q.alusrc;
  assign o_ex_memread   = ex_q.memread;
  assign o_ex_memwrite  = ex_q.memwrite;
  assign o_ex_memtoreg  = ex_q.memtoreg;
  assign o_ex_regwrite  = ex_q.regwrite;
  assign o_ex_branch    = ex_q.branch;
  assign o_ex_branch_ne = ex_q.branch_ne;
  assign o_ex_jump      = ex_q.jump;
  assign o_ex_jump_reg  = ex_q.jump_reg;
  assign o_ex_link      = ex_q.link;
  assign o_ex_aluop     = NB_ALUOP'(ex_q.aluop);
  assign o_ex_rt        = ex_rt_q;
  // A frozen pipe reports no illegal pulse
  assign o_illegal      = illegal_q & i_enable;
  assign o_halted       = halted_q;

endmodule

// File: tb/tb_control_unidad_pipe.sv
// Directed self-checking bench for control_unidad_pipe.
module tb_control_unidad_pipe;

  logic       clk, rst_n, en, valid, redirect;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt;
  logic       stall, flush, ex_valid, ex_regdst, ex_alusrc, ex_memread, ex_memwrite;
  logic       ex_memtoreg, ex_regwrite, ex_branch, ex_branch_ne, ex_jump, ex_jump_reg;
  logic       ex_link, illegal, halted;
  logic [2:0] ex_aluop;
  logic [4:0] ex_rt;

  int n_checks = 0;
  int n_fail   = 0;

  control_unidad_pipe #(.DRAIN_CYCLES(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_valid(valid),
    .i_opcode(opcode), .i_funct(funct), .i_rs(rs), .i_rt(rt),
    .i_redirect(redirect), .o_stall(stall), .o_flush(flush),
    .o_ex_valid(ex_valid), .o_ex_regdst(ex_regdst), .o_ex_alusrc(ex_alusrc),
    .o_ex_memread(ex_memread), .o_ex_memwrite(ex_memwrite),
    .o_ex_memtoreg(ex_memtoreg), .o_ex_regwrite(ex_regwrite),
    .o_ex_branch(ex_branch), .o_ex_branch_ne(ex_branch_ne),
    .o_ex_jump(ex_jump), .o_ex_jump_reg(ex_jump_reg), .o_ex_link(ex_link),
    .o_ex_aluop(ex_aluop), .o_ex_rt(ex_rt), .o_illegal(illegal), .o_halted(halted)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] s, input logic [4:0] t, input logic rd);
    valid = v; opcode = op; funct = fn; rs = s; rt = t; redirect = rd;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1;
    set_id(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 1'b0);
    tick;
    check_val("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check_val("rst_ex_rt", {27'd0, ex_rt}, 32'd0);
    check_val("rst_aluop", {29'd0, ex_aluop}, 32'd0);
    check_val("rst_illegal_halted", {30'd0, illegal, halted}, 32'd0);
    rst_n = 1'b1;
    tick;

    // ADDI -> ORI -> LW, no hazards
    set_id(1'b1, 6'b001000, 6'd0, 5'd1, 5'd2, 1'b0);
    check_val("addi_stall", {31'd0, stall}, 32'd0);
    tick;
    check_val("addi_word", {26'd0, ex_valid, ex_alusrc, ex_regwrite, ex_memtoreg, ex_aluop}, 32'b111_0_000);
    check_val("addi_rt", {27'd0, ex_rt}, 32'd2);
    set_id(1'b1, 6'b001101, 6'd0, 5'd3, 5'd4, 1'b0);
    tick;
    check_val("ori_word", {26'd0, ex_valid, ex_alusrc, ex_regwrite, ex_memtoreg, ex_aluop}, 32'b111_0_101);
    set_id(1'b1, 6'b100011, 6'd0, 5'd6, 5'd7, 1'b0);
    check_val("lw_nostall", {31'd0, stall}, 32'd0);
    tick;
    check_val("lw_word", {25'd0, ex_valid, ex_alusrc, ex_regwrite, ex_memtoreg, ex_memread, ex_aluop}, 32'b1111_1_000);

    // LW rt=5 then ADD rs=5: one stall cycle, bubble, then ADD
    set_id(1'b1, 6'b100011, 6'd0, 5'd0, 5'd5, 1'b0);
    check_val("lw5_nostall", {31'd0, stall}, 32'd0);
    tick;
    set_id(1'b1, 6'b000000, 6'b100000, 5'd5, 5'd1, 1'b0);
    check_val("lu_stall", {31'd0, stall}, 32'd1);
    tick;
    check_val("lu_bubble", {28'd0, ex_valid, ex_regwrite, ex_memread, ex_alusrc}, 32'd0);
    check_val("lu_stall_release", {31'd0, stall}, 32'd0);
    tick;
    check_val("lu_add_word", {26'd0, ex_valid, ex_regdst, ex_regwrite, ex_alusrc, ex_aluop}, 32'b1110_010);

    // LW rt=0 then ADD rs=0: no stall
    set_id(1'b1, 6'b100011, 6'd0, 5'd1, 5'd0, 1'b0);
    tick;
    set_id(1'b1, 6'b000000, 6'b100000, 5'd0, 5'd0, 1'b0);
    check_val("rt0_nostall", {31'd0, stall}, 32'd0);
    tick;
    check_val("rt0_add_valid", {30'd0, ex_valid, ex_regdst}, 32'd3);

    // LW rt=5 then dependent instruction with redirect
    set_id(1'b1, 6'b100011, 6'd0, 5'd1, 5'd5, 1'b0);
    tick;
    set_id(1'b1, 6'b000000, 6'b100000, 5'd5, 5'd2, 1'b1);
    check_val("redir_flush_stall", {30'd0, flush, stall}, 32'b10);
    tick;
    check_val("redir_bubble", {31'd0, ex_valid}, 32'd0);

    // Illegal opcode: single pulse, bubble, next ADDI normal
    set_id(1'b1, 6'b010001, 6'd0, 5'd1, 5'd1, 1'b0);
    check_val("ill_flush_clear", {30'd0, flush, stall}, 32'd0);
    tick;
    check_val("ill_pulse", {30'd0, illegal, ex_valid}, 32'b10);
    set_id(1'b1, 6'b001000, 6'd0, 5'd2, 5'd3, 1'b0);
    tick;
    check_val("ill_next_addi", {27'd0, illegal, ex_valid, ex_alusrc, ex_aluop[1:0]}, 32'b01100);

    // Other decodes: BNE, JAL, JR, SW
    set_id(1'b1, 6'b000101, 6'd0, 5'd2, 5'd3, 1'b0);
    tick;
    check_val("bne_word", {26'd0, ex_branch, ex_branch_ne, ex_regwrite, ex_aluop}, 32'b010_001);
    set_id(1'b1, 6'b000011, 6'd0, 5'd0, 5'd0, 1'b0);
    tick;
    check_val("jal_word", {26'd0, ex_jump, ex_link, ex_regwrite, ex_aluop}, 32'b111_000);
    set_id(1'b1, 6'b000000, 6'b001000, 5'd4, 5'd0, 1'b0);
    tick;
    check_val("jr_word", {26'd0, ex_jump_reg, ex_regdst, ex_regwrite, ex_aluop}, 32'b100_000);
    set_id(1'b1, 6'b101011, 6'd0, 5'd4, 5'd9, 1'b0);
    tick;
    check_val("sw_word", {26'd0, ex_memwrite, ex_regwrite, ex_alusrc, ex_aluop}, 32'b101_000);

    // HALT with a two-cycle enable gap in the drain
    set_id(1'b1, 6'b111111, 6'd0, 5'd0, 5'd0, 1'b0);
    check_val("halt_decode_stall", {31'd0, stall}, 32'd1);
    tick; // edge N
    check_val("halt_n", {30'd0, halted, ex_valid}, 32'd0);
    set_id(1'b1, 6'b001000, 6'd0, 5'd1, 5'd2, 1'b1);
    check_val("drain_stall", {31'd0, stall}, 32'd1);
    tick; // N+1
    check_val("halt_n1", {30'd0, halted, ex_valid}, 32'd0);
    en = 1'b0;
    #1;
    check_val("dis_stall_flush", {30'd0, stall, flush}, 32'd0);
    tick;
    tick;
    check_val("halt_dis", {31'd0, halted}, 32'd0);
    en = 1'b1;
    tick; // N+2
    check_val("halt_n2", {31'd0, halted}, 32'd0);
    tick; // N+3
    check_val("halt_n3", {30'd0, halted, stall}, 32'b11);
    set_id(1'b1, 6'b001000, 6'd0, 5'd1, 5'd2, 1'b0);
    tick;
    check_val("halted_bubble", {30'd0, halted, ex_valid}, 32'b10);

    // Asynchronous reset clears halted mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_halted", {31'd0, halted}, 32'd0);
    tick;
    rst_n = 1'b1;
    set_id(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 1'b0);
    check_val("post_rst_run", {31'd0, stall}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
